ram512_reader: RTL

Sequential read engine for the RAM512 memory. Given a start address and a word count, it walks RAM512 addresses, with wrap-around at 512, and streams each 16-bit word out over a valid/ready handshake. It is the read-side counterpart to the RAM512 write path and lets downstream logic (display scanout, serial dump, verification) drain a memory region without address bookkeeping. It sits beside RAM512 and drives its `address` input while a transfer is in progress.

---
 rtl/ram512_reader_if.sv | 25 ++
 rtl/ram512_reader.sv | 118 +++++++++++
 2 files changed

// File: rtl/ram512_reader_if.sv
// Bus bundle for ram512_reader: transfer control, RAM512 read port and output stream.
// master: the reader engine. slave: the environment (requester, RAM512, consumer).
interface ram512_reader_if;
    logic        start;
    logic [8:0]  base;
    logic [9:0]  count;
    logic [8:0]  ram_address;
    logic [15:0] ram_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    modport master (
        input  start, base, count, ram_data, out_ready,
        output ram_address, out_data, out_valid, busy, done, checksum
    );

    modport slave (
        output start, base, count, ram_data, out_ready,
        input  ram_address, out_data, out_valid, busy, done, checksum
    );
endinterface

// File: rtl/ram512_reader.sv
// ram512_reader: walks RAM512 from a base address (wrapping at 512) and streams
// each 16-bit word over a valid/ready handshake.
// Optional macro RAM512_READER_CHECKSUM_EN builds a running sum of accepted words;
// without it the checksum output is tied to 0.
module ram512_reader (
    input  logic           clk,
    input  logic           reset,
    ram512_reader_if.master bus
);
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned DEPTH  = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    remaining;
    logic [ADDR_W-1:0]   ram_address;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    count_clamped_c;
    logic                handshake_c;
    logic                capture_c;

    // Requests above the memory depth read the whole memory exactly once.
    assign count_clamped_c = (bus.count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.count;
    assign handshake_c     = out_valid && bus.out_ready;
    assign capture_c       = !out_valid || bus.out_ready;

    // Transfer sequencing, address walk and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            ram_address <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ram_address <= bus.base;
                        remaining   <= count_clamped_c;
                        if (count_clamped_c == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= STREAM;
                            busy  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (capture_c) begin
                        out_data    <= bus.ram_data;
                        out_valid   <= 1'b1;
                        ram_address <= ram_address + ADDR_W'(1);
                        remaining   <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake_c) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM512_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    // Sum of accepted words, cleared when a new transfer is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == IDLE && bus.start) begin
            checksum <= '0;
        end else if (handshake_c) begin
            checksum <= checksum + out_data;
        end
    end

    assign bus.checksum = checksum;
`else
    assign bus.checksum = '0;
`endif

    assign bus.ram_address = ram_address;
    assign bus.out_data    = out_data;
    assign bus.out_valid   = out_valid;
    assign bus.busy        = busy;
    assign bus.done        = done;

endmodule
